// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: turns one-cycle key events into a multi-digit BCD entry
// and hands the completed entry downstream over a valid/ready handshake.
module keypad_entry_ctrl #(
    parameter int unsigned MAX_DIGITS  = 4,
    parameter int unsigned TIMEOUT_CYC = 50000000,
    parameter logic [3:0]  KEY_BS      = 4'hA,
    parameter logic [3:0]  KEY_CLR     = 4'hB,
    parameter logic [3:0]  KEY_ENT     = 4'hF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [3:0]                          key_num,
    input  logic                                key_toggle,
    input  logic                                out_ready,
    output logic                                out_valid,
    output logic [4*MAX_DIGITS-1:0]             out_digits,
    output logic [$clog2(MAX_DIGITS+1)-1:0]     out_cnt,
    output logic [4*MAX_DIGITS-1:0]             live_digits,
    output logic [$clog2(MAX_DIGITS+1)-1:0]     live_cnt,
    output logic                                busy,
    output logic                                timeout,
    output logic                                overflow,
    output logic [1:0]                          dbg_state
);
    localparam int unsigned DW = 4 * MAX_DIGITS;
    localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] C_MAX  = CW'(MAX_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t        state_q;
    logic [DW-1:0] buf_q;
    logic [CW-1:0] cnt_q;
    logic [TW-1:0] timer_q;
    logic          valid_q;
    logic [DW-1:0] out_digits_q;
    logic [CW-1:0] out_cnt_q;
    logic          timeout_q;
    logic          overflow_q;

    logic is_digit, is_bs, is_clr, is_ent;

    always_comb begin
        is_digit = key_toggle && (key_num <= 4'd9);
        is_bs    = key_toggle && (key_num == KEY_BS);
        is_clr   = key_toggle && (key_num == KEY_CLR);
        is_ent   = key_toggle && (key_num == KEY_ENT);
    end

    // Handshake: out_valid rises with the ENT capture and holds, together with
    // out_digits/out_cnt, until the edge where out_valid && out_ready; that edge
    // is the transfer and drops out_valid. out_ready is ignored otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            cnt_q        <= '0;
            timer_q      <= '0;
            valid_q      <= 1'b0;
            out_digits_q <= '0;
            out_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (is_digit) begin
                        buf_q   <= DW'(key_num);
                        cnt_q   <= CW'(1);
                        timer_q <= '0;
                        state_q <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (is_digit) begin
                        timer_q <= '0;
                        if (cnt_q < C_MAX) begin
                            buf_q <= DW'({buf_q, 4'h0}) | DW'(key_num);
                            cnt_q <= cnt_q + CW'(1);
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end else if (is_bs) begin
                        timer_q <= '0;
                        buf_q   <= buf_q >> 4;
                        cnt_q   <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) state_q <= S_IDLE;
                    end else if (is_clr) begin
                        timer_q <= '0;
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (is_ent) begin
                        timer_q      <= '0;
                        out_digits_q <= buf_q;
                        out_cnt_q    <= cnt_q;
                        valid_q      <= 1'b1;
                        state_q      <= S_HOLD;
                    end else if (timer_q == T_LAST) begin
                        timer_q   <= '0;
                        buf_q     <= '0;
                        cnt_q     <= '0;
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_HOLD: begin
                    // Keys are dropped here; the buffer stays visible until transfer.
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid   = valid_q;
    assign out_digits  = out_digits_q;
    assign out_cnt     = out_cnt_q;
    assign live_digits = buf_q;
    assign live_cnt    = cnt_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout     = timeout_q;
    assign overflow    = overflow_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed keypad scenarios plus random key traffic,
// checked against a digit-queue reference model and an entry scoreboard.
module tb_keypad_entry_ctrl;
    localparam int MAXD = 4;
    localparam int TCYC = 8;
    localparam int DW   = 4 * MAXD;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int W    = CW + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    key_num;
    logic          key_toggle;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_digits;
    logic [CW-1:0] out_cnt;
    logic [DW-1:0] live_digits;
    logic [CW-1:0] live_cnt;
    logic          busy;
    logic          timeout;
    logic          overflow;
    logic [1:0]    dbg_state;

    keypad_entry_ctrl #(
        .MAX_DIGITS (MAXD),
        .TIMEOUT_CYC(TCYC),
        .KEY_BS     (4'hA),
        .KEY_CLR    (4'hB),
        .KEY_ENT    (4'hF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_num    (key_num),
        .key_toggle (key_toggle),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_digits (out_digits),
        .out_cnt    (out_cnt),
        .live_digits(live_digits),
        .live_cnt   (live_cnt),
        .busy       (busy),
        .timeout    (timeout),
        .overflow   (overflow),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    // Reference model: digits held as a list, oldest first.
    int m_digits[$];
    int m_mode;        // 0 idle, 1 typing, 2 waiting for downstream
    int m_idle;        // idle cycles since last recognised key while typing
    int m_valid, m_ocnt, m_to, m_ov;
    int m_odig;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int pack_digits();
        int v = 0;
        foreach (m_digits[i]) v = v * 16 + m_digits[i];
        return v;
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_mode = 0; m_idle = 0; m_valid = 0; m_ocnt = 0; m_odig = 0; m_to = 0; m_ov = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        int  k;
        bit  dig, rec;
        k   = int'(key_num);
        dig = key_toggle && (k <= 9);
        rec = dig || (key_toggle && (k == 10 || k == 11 || k == 15));
        if (rst) begin
            model_reset();
            return;
        end
        m_to = 0; m_ov = 0;
        if (m_mode == 0) begin
            if (dig) begin
                m_digits = '{k};
                m_mode = 1; m_idle = 0;
            end
        end else if (m_mode == 1) begin
            if (rec) begin
                m_idle = 0;
                if (dig) begin
                    if (m_digits.size() < MAXD) m_digits.push_back(k);
                    else m_ov = 1;
                end else if (k == 10) begin
                    void'(m_digits.pop_back());
                    if (m_digits.size() == 0) m_mode = 0;
                end else if (k == 11) begin
                    m_digits.delete();
                    m_mode = 0;
                end else begin
                    m_odig  = pack_digits();
                    m_ocnt  = m_digits.size();
                    m_valid = 1;
                    m_mode  = 2;
                    exp_q.push_back({CW'(m_ocnt), DW'(m_odig)});
                end
            end else if (m_idle == TCYC - 1) begin
                m_digits.delete();
                m_mode = 0; m_idle = 0; m_to = 1;
            end else begin
                m_idle++;
            end
        end else begin
            if (out_ready) begin
                m_valid = 0;
                m_digits.delete();
                m_mode = 0;
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("live_cnt", int'(live_cnt), m_digits.size());
        check("live_digits", int'(live_digits), pack_digits());
        check("busy", int'(busy), int'(m_mode != 0));
        check("out_valid", int'(out_valid), m_valid);
        check("out_digits", int'(out_digits), m_odig);
        check("out_cnt", int'(out_cnt), m_ocnt);
        check("timeout", int'(timeout), m_to);
        check("overflow", int'(overflow), m_ov);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input logic [3:0] k);
        key_toggle = 1'b1;
        key_num    = k;
        step();
        key_toggle = 1'b0;
        key_num    = $urandom_range(0, 15);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every completed transfer must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_transfer", 1, 0);
            end else begin
                check("entry", int'({out_cnt, out_digits}), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; key_toggle = 1'b0; key_num = 4'h0; out_ready = 1'b1;
        model_reset();
        step();
        check("reset_live_cnt", int'(live_cnt), 0);
        check("reset_out_valid", int'(out_valid), 0);
        step();
        rst = 1'b0;

        // 1,2,3 ENT with downstream ready
        press(4'h1); press(4'h2); press(4'h3); press(4'hF);
        check("ent_valid_next_cycle", int'(out_valid), 1);
        check("ent_digits_123", int'(out_digits[11:0]), 'h123);
        check("ent_cnt_3", int'(out_cnt), 3);
        idle(3);

        // Overflow on the fifth digit
        press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'h9);
        check("overflow_5th", int'(overflow), 1);
        check("overflow_keeps_5678", int'(live_digits), 'h5678);
        press(4'hF);
        check("full_cnt_4", int'(out_cnt), 4);
        idle(3);

        // Backspace to empty, then clear
        press(4'h4); press(4'h2); press(4'hA); press(4'hA);
        check("bs_to_idle", int'(busy), 0);
        press(4'h7); press(4'hB);
        check("clr_cnt_0", int'(live_cnt), 0);
        idle(2);

        // Timeout after idle, then a late key cancelling it
        press(4'h3); idle(TCYC + 2);
        press(4'h3); idle(TCYC - 2); press(4'h2); idle(TCYC - 2);
        press(4'hB); idle(2);

        // Hold with downstream stalled while keys arrive
        out_ready = 1'b0;
        press(4'h1); press(4'h9); press(4'hF);
        press(4'h3); press(4'hA); press(4'hB); press(4'h8); press(4'hF);
        check("hold_digits_stable", int'(out_digits), 'h19);
        out_ready = 1'b1;
        idle(3);

        // Reset in typing and in hold; unassigned codes
        press(4'h1); press(4'h2); do_reset();
        check("rst_entry_cnt", int'(live_cnt), 0);
        out_ready = 1'b0;
        press(4'h2); press(4'hF); do_reset();
        check("rst_hold_valid", int'(out_valid), 0);
        out_ready = 1'b1;
        press(4'hC); press(4'hD); press(4'hE);
        press(4'h6); press(4'hC); press(4'hD); press(4'hE); press(4'hB);
        idle(2);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            key_toggle = ($urandom_range(0, 2) == 0);
            key_num    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                                     : 4'($urandom_range(0, 9));
            out_ready  = ($urandom_range(0, 1) == 1);
            step();
        end
        rst = 1'b0; key_toggle = 1'b0; out_ready = 1'b1;
        idle(TCYC + 4);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
